vga_pattern_gen_seq: RTL

//   Registered, parametrised VGA test pattern generator. Sits between the sync/pixel counter
//   and the VGA output stage. Produces one RGB pixel per valid input coordinate with a fixed
//   1-cycle latency. Adds frame-synchronous pattern switching, animated patterns and an

---
 rtl/vga_pattern_gen_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen_seq.sv
// VGA test pattern generator: one registered RGB pixel per active
// coordinate, frame-synchronous pattern switch, animated and auto-cycle modes.
// Ports:
//   i_clk, i_reset (sync, active-high)
//   i_pattern, i_auto, i_frame_start: pattern control
//   i_valid, i_x, i_y: pixel coordinate in
//   o_valid, o_red, o_green, o_blue: pixel out (1-cycle latency)
//   o_pattern: pattern index in effect
module vga_pattern_gen_seq #(
  parameter int COLOR_BITS  = 3,
  parameter int COORD_BITS  = 11,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int TILE_LOG2   = 4,
  parameter int AUTO_FRAMES = 60,
  parameter int BAR_STEP    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [3:0]            i_pattern,
  input  logic                  i_auto,
  input  logic                  i_frame_start,
  input  logic                  i_valid,
  input  logic [COORD_BITS-1:0] i_x,
  input  logic [COORD_BITS-1:0] i_y,
  output logic                  o_valid,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_green,
  output logic [COLOR_BITS-1:0] o_blue,
  output logic [3:0]            o_pattern
);

  localparam int DIV_W = $clog2(AUTO_FRAMES + 1);
  localparam int WW    = COORD_BITS + 1;
  localparam logic [COLOR_BITS-1:0] FULL = '1;
  localparam logic [COLOR_BITS-1:0] NONE = '0;

  logic [7:0]            frame_cnt;
  logic [COORD_BITS-1:0] bar_x;
  logic [DIV_W-1:0]      div;
  logic [3:0]            auto_pat;

  logic [WW-1:0]         bar_sum;
  logic [COORD_BITS-1:0] bar_next;
  logic [DIV_W-1:0]      div_next;
  logic [3:0]            auto_next;

  logic [WW-1:0]         x_w;
  logic [WW-1:0]         bar_lo;
  logic [WW-1:0]         bar_hi;
  logic                  in_bar;
  logic                  on_edge;
  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;

  // Bar advance with wrap at the active width.
  always_comb begin
    bar_sum = {1'b0, bar_x} + WW'(BAR_STEP);
    if (bar_sum >= WW'(ACTIVE_COLS))
      bar_sum = bar_sum - WW'(ACTIVE_COLS);
    bar_next = bar_sum[COORD_BITS-1:0];
  end

  // Auto divider compares its old value, so the first
  // pattern holds for AUTO_FRAMES-1 frame starts after entry.
  always_comb begin
    div_next  = div + DIV_W'(1);
    auto_next = auto_pat;
    if (div == DIV_W'(AUTO_FRAMES - 1)) begin
      div_next  = '0;
      auto_next = (auto_pat == 4'd11) ? 4'd0 : auto_pat + 4'd1;
    end
  end

  // One extra bit keeps bar_x + tile from overflowing near wrap.
  always_comb begin
    x_w    = {1'b0, i_x};
    bar_lo = {1'b0, bar_x};
    bar_hi = bar_lo + WW'(2 ** TILE_LOG2);
    in_bar = (x_w >= bar_lo) && (x_w < bar_hi);
  end

  assign on_edge = (i_x == '0) || (i_y == '0)
    || (i_x == COORD_BITS'(ACTIVE_COLS - 1))
    || (i_y == COORD_BITS'(ACTIVE_ROWS - 1));

  always_comb begin
    r = NONE;
    g = NONE;
    b = NONE;
    unique case (o_pattern)
      4'd1: r = FULL;
      4'd2: g = FULL;
      4'd3: b = FULL;
      4'd4: begin
        r = (i_x[TILE_LOG2] ^ i_y[TILE_LOG2]) ? FULL : NONE;
        g = r;
        b = r;
      end
      4'd5: begin
        r = i_x[TILE_LOG2]     ? FULL : NONE;
        g = i_x[TILE_LOG2 + 1] ? FULL : NONE;
        b = i_x[TILE_LOG2 + 2] ? FULL : NONE;
      end
      4'd6: begin
        r = i_y[TILE_LOG2]     ? FULL : NONE;
        g = i_y[TILE_LOG2 + 1] ? FULL : NONE;
        b = i_y[TILE_LOG2 + 2] ? FULL : NONE;
      end
      4'd7: begin
        r = FULL;
        g = FULL;
        b = FULL;
      end
      4'd8: begin
        r = i_x[TILE_LOG2 +: COLOR_BITS];
        g = i_y[TILE_LOG2 +: COLOR_BITS];
      end
      4'd9: begin
        r = in_bar ? FULL : NONE;
        g = r;
        b = r;
      end
      4'd10: begin
        r = on_edge ? FULL : NONE;
        g = r;
        b = r;
      end
      4'd11: begin
        r = frame_cnt[COLOR_BITS-1:0];
        g = r;
        b = r;
      end
      default: begin
        r = NONE;
        g = NONE;
        b = NONE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_red     <= '0;
      o_green   <= '0;
      o_blue    <= '0;
      o_pattern <= 4'd0;
      frame_cnt <= 8'd0;
      bar_x     <= '0;
      div       <= '0;
      auto_pat  <= 4'd0;
    end else begin
      o_valid <= i_valid;
      o_red   <= i_valid ? r : NONE;
      o_green <= i_valid ? g : NONE;
      o_blue  <= i_valid ? b : NONE;
      if (!i_auto) begin
        div      <= '0;
        auto_pat <= 4'd0;
      end
      if (i_frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
        bar_x     <= bar_next;
        if (i_auto) begin
          div       <= div_next;
          auto_pat  <= auto_next;
          o_pattern <= auto_next;
        end else begin
          o_pattern <= i_pattern;
        end
      end
    end
  end

endmodule
